// File: rtl/operand_sort_comparator.sv
// Multi-cycle unsigned magnitude comparator and operand sorter.
// Compares MSB-first, CHUNK bits per cycle, and stops at the first differing chunk.
module operand_sort_comparator #(
    parameter int unsigned W     = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         beg_comp,
    input  logic [W-1:0] Data_A,
    input  logic [W-1:0] Data_B,
    output logic         busy,
    output logic         done,
    output logic         gthan,
    output logic         equal,
    output logic         swap,
    output logic [W-1:0] Data_Max,
    output logic [W-1:0] Data_Min
);

    localparam int unsigned N  = W / CHUNK;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        COMPARE
    } state_t;

    state_t                  state_q, state_d;
    logic [N-1:0][CHUNK-1:0] a_q, a_d, b_q, b_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    busy_d, done_d, gthan_d, equal_d, swap_d;
    logic [W-1:0]            max_d, min_d;
    logic [CHUNK-1:0]        a_chunk, b_chunk;

    // Operands are held as chunk arrays so the active chunk is a plain index
    assign a_chunk = a_q[idx_q];
    assign b_chunk = b_q[idx_q];

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            idx_q    <= IW'(N - 1);
            busy     <= 1'b0;
            done     <= 1'b0;
            gthan    <= 1'b0;
            equal    <= 1'b0;
            swap     <= 1'b0;
            Data_Max <= '0;
            Data_Min <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            idx_q    <= idx_d;
            busy     <= busy_d;
            done     <= done_d;
            gthan    <= gthan_d;
            equal    <= equal_d;
            swap     <= swap_d;
            Data_Max <= max_d;
            Data_Min <= min_d;
        end
    end

    // Next-state and output logic; results hold until the next completion
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        idx_d   = idx_q;
        busy_d  = busy;
        done_d  = 1'b0;
        gthan_d = gthan;
        equal_d = equal;
        swap_d  = swap;
        max_d   = Data_Max;
        min_d   = Data_Min;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (beg_comp) begin
                    a_d     = Data_A;
                    b_d     = Data_B;
                    idx_d   = IW'(N - 1);
                    busy_d  = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (a_chunk > b_chunk) begin
                    gthan_d = 1'b1;
                    equal_d = 1'b0;
                    swap_d  = 1'b0;
                    max_d   = a_q;
                    min_d   = b_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (a_chunk < b_chunk) begin
                    gthan_d = 1'b0;
                    equal_d = 1'b0;
                    swap_d  = 1'b1;
                    max_d   = b_q;
                    min_d   = a_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (idx_q == '0) begin
                    gthan_d = 1'b0;
                    equal_d = 1'b1;
                    swap_d  = 1'b0;
                    max_d   = a_q;
                    min_d   = b_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_operand_sort_comparator.sv
// Scoreboard bench for operand_sort_comparator: the driver queues expected results,
// and the monitor checks them whenever done is presented.
module tb_operand_sort_comparator;

    localparam int unsigned W     = 32;
    localparam int unsigned CHUNK = 8;
    localparam int unsigned N     = W / CHUNK;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         beg_comp;
    logic [W-1:0] Data_A, Data_B;
    logic         busy, done, gthan, equal, swap;
    logic [W-1:0] Data_Max, Data_Min;

    operand_sort_comparator #(.W(W), .CHUNK(CHUNK)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .beg_comp (beg_comp),
        .Data_A   (Data_A),
        .Data_B   (Data_B),
        .busy     (busy),
        .done     (done),
        .gthan    (gthan),
        .equal    (equal),
        .swap     (swap),
        .Data_Max (Data_Max),
        .Data_Min (Data_Min)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] mx;
        logic [W-1:0] mn;
        logic         gt;
        logic         eq;
        logic         sw;
        int           acc_cyc;
        int           done_cyc;
    } exp_t;

    exp_t q[$];
    exp_t held;
    int   cyc = 0;
    int   last_done = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Number of compare steps: position of the first differing chunk from the MSB
    function automatic int latency(input logic [W-1:0] a, input logic [W-1:0] b);
        for (int k = 1; k <= int'(N); k++) begin
            int sh = int'(W) - k * int'(CHUNK);
            if ((a >> sh) != (b >> sh)) return k;
        end
        return int'(N);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        while (cyc < last_done) tick();
    endtask

    task automatic start(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.gt       = (a > b);
        e.sw       = (b > a);
        e.eq       = (a == b);
        e.mx       = (b > a) ? b : a;
        e.mn       = (b > a) ? a : b;
        e.acc_cyc  = cyc + 1;
        e.done_cyc = cyc + 1 + latency(a, b);
        q.push_back(e);
        last_done = e.done_cyc;
        beg_comp  = 1'b1;
        Data_A    = a;
        Data_B    = b;
        tick();
        beg_comp  = 1'b0;
        Data_A    = $urandom;
        Data_B    = $urandom;
    endtask

    // Monitor: checks busy/done timing, pops on done, and checks held results every cycle
    always @(negedge clk) begin
        if (mon_en) begin
            bit exp_busy, exp_done;
            exp_busy = (q.size() > 0) && (cyc >= q[0].acc_cyc) && (cyc < q[0].done_cyc);
            exp_done = (q.size() > 0) && (cyc == q[0].done_cyc);
            chk("busy", 64'(busy), 64'(exp_busy));
            chk("done", 64'(done), 64'(exp_done));
            if (exp_done) held = q.pop_front();
            chk("gthan", 64'(gthan), 64'(held.gt));
            chk("equal", 64'(equal), 64'(held.eq));
            chk("swap", 64'(swap), 64'(held.sw));
            chk("Data_Max", 64'(Data_Max), 64'(held.mx));
            chk("Data_Min", 64'(Data_Min), 64'(held.mn));
        end
    end

    task automatic clear_held();
        held.mx = '0;
        held.mn = '0;
        held.gt = 1'b0;
        held.eq = 1'b0;
        held.sw = 1'b0;
    endtask

    initial begin
        logic [W-1:0] a, b, mask;
        int           j;
        rst_n    = 1'b0;
        beg_comp = 1'b0;
        Data_A   = '0;
        Data_B   = '0;
        clear_held();
        tick();
        tick();
        rst_n     = 1'b1;
        last_done = cyc;
        mon_en    = 1'b1;
        tick();

        // Directed cases
        wait_idle(); start(32'h8000_0000, 32'h7FFF_FFFF);
        wait_idle(); start(32'h0000_0001, 32'h0000_0002);
        wait_idle(); start(32'h1234_5678, 32'h1234_5678);

        // Request while busy must be ignored
        wait_idle();
        start(32'h00FF_0000, 32'h0001_0000);
        beg_comp = 1'b1;
        Data_A   = 32'h0000_0000;
        Data_B   = 32'hFFFF_FFFF;
        tick();
        beg_comp = 1'b0;

        // Reset mid-comparison aborts without a done pulse
        wait_idle();
        start(32'h1111_1111, 32'h1111_1112);
        tick();
        rst_n = 1'b0;
        tick();
        q.delete();
        clear_held();
        last_done = cyc;
        rst_n = 1'b1;
        start(32'h1111_1111, 32'h1111_1112);

        // Back-to-back: new start issued in the done cycle
        wait_idle(); start(32'd5, 32'd3);
        wait_idle(); start(32'd3, 32'd5);

        // Randomized operands with a controlled number of equal leading chunks
        for (int i = 0; i < 300; i++) begin
            a = $urandom;
            j = $urandom_range(0, N - 1);
            mask = (j == 0) ? '0 : ({W{1'b1}} << (W - j * CHUNK));
            if ($urandom_range(0, 4) == 0) b = a;
            else b = (a & mask) | (W'($urandom) & ~mask);
            if ($urandom_range(0, 1) == 0) begin
                logic [W-1:0] t;
                t = a; a = b; b = t;
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) tick();
            start(a, b);
            if ($urandom_range(0, 3) == 0 && cyc < last_done) begin
                beg_comp = 1'b1;
                Data_A   = $urandom;
                Data_B   = $urandom;
                tick();
                beg_comp = 1'b0;
            end
        end

        wait_idle();
        repeat (3) tick();
        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
